// File: rtl/sr_lock_arbiter_if.sv
// Bundles the requester handshake and the sr_ff drive/feedback lines of the lock arbiter.
// master: requester logic plus the sr_ff model; slave: the arbiter itself.
interface sr_lock_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] acq_req;
  logic [N_REQ-1:0] rel_req;
  logic [N_REQ-1:0] grant;
  logic             sr_q;
  logic             sr_s;
  logic             sr_r;
  logic             busy;
  logic             tmo;
  logic             fault;

  modport master (
    output acq_req, rel_req, sr_q,
    input  sr_s, sr_r, grant, busy, tmo, fault
  );

  modport slave (
    input  acq_req, rel_req, sr_q,
    output sr_s, sr_r, grant, busy, tmo, fault
  );
endinterface

// File: rtl/sr_lock_arbiter.sv
// Round-robin mutex controller around one external sr_ff used as a lock flag.
// Drives s/r, waits for q to follow before granting or returning to idle, forces
// release after a hold timeout and latches a sticky fault if q never follows.
module sr_lock_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16,
  parameter int CW      = 8,
  parameter int WDOG    = 4
) (
  input  logic clk,
  input  logic rst,
  sr_lock_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = (WDOG > 1) ? $clog2(WDOG) : 1;

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_SET    = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;
  localparam logic [2:0] S_CLR    = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  logic [2:0]       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [CW-1:0]    cnt;
  logic [WW-1:0]    wd;
  logic             fault_q;
  logic             tmo_q;

  logic [PW-1:0]    win;
  logic             found;
  logic [N_REQ-1:0] grant_d;
  logic             wd_hit;
  logic             to_hit;
  logic [PW-1:0]    ptr_next;

  assign wd_hit   = (wd == WW'(WDOG - 1));
  assign to_hit   = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  assign ptr_next = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // Round-robin pick: first asserted acquire scanning upward from ptr, wrapping at N_REQ.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && bus.acq_req[j]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
  end

  // Grant is decoded from registered state/owner only, so it never glitches on inputs.
  always_comb begin
    grant_d = '0;
    if (state == S_LOCKED) grant_d[owner] = 1'b1;
  end

  assign bus.grant = grant_d;
  assign bus.sr_s  = (state == S_SET);
  // INIT, CLR and FAULT all hold the flag cleared; SET is exclusive, so s&r is never 1.
  assign bus.sr_r  = (state == S_INIT) || (state == S_CLR) || (state == S_FAULT);
  assign bus.busy  = (state != S_IDLE);
  assign bus.tmo   = tmo_q;
  assign bus.fault = fault_q;

  // Lock sequencer: state, owner/pointer, hold counter, watchdog and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_INIT;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      wd      <= '0;
      fault_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state)
        // sr_ff powers up unknown; clear it before offering the lock.
        S_INIT: begin
          if (!bus.sr_q) state <= S_IDLE;
          else if (wd_hit) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
          end else wd <= wd + 1'b1;
        end
        S_IDLE: begin
          if (found) begin
            owner <= win;
            state <= S_SET;
            wd    <= '0;
          end
        end
        S_SET: begin
          if (bus.sr_q) begin
            state <= S_LOCKED;
            cnt   <= '0;
          end else if (wd_hit) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
          end else wd <= wd + 1'b1;
        end
        // Release beats timeout when both land in the same cycle.
        S_LOCKED: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (bus.rel_req[owner]) begin
            state <= S_CLR;
            wd    <= '0;
          end else if (to_hit) begin
            state <= S_CLR;
            tmo_q <= 1'b1;
            wd    <= '0;
          end
        end
        S_CLR: begin
          if (!bus.sr_q) begin
            state <= S_IDLE;
            ptr   <= ptr_next;
          end else if (wd_hit) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
          end else wd <= wd + 1'b1;
        end
        S_FAULT: ;
        default: state <= S_FAULT;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_lock_arbiter.sv
// Bench for sr_lock_arbiter: behavioural sr_ff closes the loop; per-cycle vectors from
// a table feed a scoreboard queue, plus a hand sequence for async reset mid-lock.
module tb_sr_lock_arbiter;
  typedef struct {
    string      nm;
    logic       rs;
    logic       st;
    logic [3:0] acq;
    logic [3:0] rel;
    int         n;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    string      nm;
    logic [8:0] exp;
  } sb_t;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic stuck = 1'b0;
  logic q_ff  = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  vec_t tbl[$];
  sb_t  sbq[$];

  sr_lock_arbiter_if #(.N_REQ(4)) bus ();

  sr_lock_arbiter #(.N_REQ(4), .TIMEOUT(16), .CW(8), .WDOG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Controlled sr_ff (no reset); stuck forces q low to provoke the watchdog.
  always @(posedge clk) begin
    if (bus.sr_s) q_ff <= 1'b1;
    else if (bus.sr_r) q_ff <= 1'b0;
  end
  assign bus.sr_q = stuck ? 1'b0 : q_ff;

  // Every cycle: s/r never together, grant at most one-hot.
  always @(negedge clk) begin
    checks++;
    if ((bus.sr_s && bus.sr_r) || !$onehot0(bus.grant)) begin
      fails++;
      $display("FAIL invariant: s=%b r=%b grant=%b", bus.sr_s, bus.sr_r, bus.grant);
    end
  end

  function automatic logic [8:0] o(logic [3:0] g, logic b, logic s, logic r, logic t, logic f);
    return {g, b, s, r, t, f};
  endfunction

  function automatic logic [8:0] act();
    return {bus.grant, bus.busy, bus.sr_s, bus.sr_r, bus.tmo, bus.fault};
  endfunction

  task automatic add(string nm, logic rs, logic st, logic [3:0] a, logic [3:0] rl, int n,
                     logic [8:0] e);
    vec_t v;
    v.nm = nm; v.rs = rs; v.st = st; v.acq = a; v.rel = rl; v.n = n; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic cmp(string nm, logic [8:0] a, logic [8:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b want %b (grant,busy,s,r,tmo,fault)", nm, a, e);
    end
  endtask

  initial begin
    logic [8:0] xi, xd, xs, xc, xt, xf;
    logic [3:0] ow;
    sb_t        sb;
    xi = o(4'b0000, 1, 0, 1, 0, 0);  // INIT
    xd = o(4'b0000, 0, 0, 0, 0, 0);  // IDLE
    xs = o(4'b0000, 1, 1, 0, 0, 0);  // SET
    xc = o(4'b0000, 1, 0, 1, 0, 0);  // CLR
    xt = o(4'b0000, 1, 0, 1, 1, 0);  // CLR, timeout pulse
    xf = o(4'b0000, 1, 0, 1, 0, 1);  // FAULT

    bus.acq_req = '0;
    bus.rel_req = '0;
    #1 rst = 1'b1;
    #1 cmp("reset_outputs", act(), xi);
    #1 rst = 1'b0;

    // Power-up: q starts 1, INIT holds r until q clears.
    add("init_q1",   0, 0, 4'b0000, 4'b0000, 1, xi);
    add("init_idle", 0, 0, 4'b0000, 4'b0000, 3, xd);
    // Single acquire/release of requester 2.
    add("t2_set",    0, 0, 4'b0100, 4'b0000, 2, xs);
    add("t2_lock",   0, 0, 4'b0100, 4'b0000, 2, o(4'b0100, 1, 0, 0, 0, 0));
    add("t2_clr",    0, 0, 4'b0000, 4'b0100, 2, xc);
    add("t2_idle",   0, 0, 4'b0000, 4'b0000, 1, xd);
    // All request: rotation from ptr=3; non-owner releases are ignored.
    for (int k = 0; k < 5; k++) begin
      ow = 4'b0001 << ((3 + k) % 4);
      add($sformatf("rr%0d_set", k),  0, 0, 4'b1111, 4'b0000, 2, xs);
      add($sformatf("rr%0d_lock", k), 0, 0, 4'b1111, ~ow, 3, o(ow, 1, 0, 0, 0, 0));
      add($sformatf("rr%0d_clr", k),  0, 0, 4'b1111, ow, 2, xc);
      add($sformatf("rr%0d_idle", k), 0, 0, 4'b0000, 4'b0000, 1, xd);
    end
    // Timeout: 16 LOCKED cycles then forced release with one tmo pulse.
    add("to_set",    0, 0, 4'b0001, 4'b0000, 2, xs);
    add("to_lock",   0, 0, 4'b0001, 4'b0000, 16, o(4'b0001, 1, 0, 0, 0, 0));
    add("to_expire", 0, 0, 4'b0000, 4'b0000, 1, xt);
    add("to_clr",    0, 0, 4'b0000, 4'b0000, 1, xc);
    add("to_idle",   0, 0, 4'b0000, 4'b0000, 1, xd);
    // Release on the expiry cycle: release wins, no tmo.
    add("tr_set",    0, 0, 4'b0010, 4'b0000, 2, xs);
    add("tr_lock",   0, 0, 4'b0010, 4'b0000, 16, o(4'b0010, 1, 0, 0, 0, 0));
    add("tr_rel",    0, 0, 4'b0000, 4'b0010, 2, xc);
    add("tr_idle",   0, 0, 4'b0000, 4'b0000, 1, xd);
    // q stuck low: 4 cycles in SET then sticky fault.
    add("wd_set",    0, 1, 4'b0100, 4'b0000, 4, xs);
    add("wd_fault",  0, 1, 4'b0100, 4'b0000, 3, xf);
    add("wd_sticky", 0, 0, 4'b0001, 4'b0000, 2, xf);
    add("wd_rst",    1, 0, 4'b0000, 4'b0000, 1, xi);
    add("wd_idle",   0, 0, 4'b0000, 4'b0000, 1, xd);
    // acq dropped during SET: lock still granted.
    add("dr_set",    0, 0, 4'b0010, 4'b0000, 1, xs);
    add("dr_set2",   0, 0, 4'b0000, 4'b0000, 1, xs);
    add("dr_lock",   0, 0, 4'b0000, 4'b0000, 2, o(4'b0010, 1, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        rst         = tbl[i].rs;
        stuck       = tbl[i].st;
        bus.acq_req = tbl[i].acq;
        bus.rel_req = tbl[i].rel;
        sb.nm  = $sformatf("%s[%0d]", tbl[i].nm, k);
        sb.exp = tbl[i].exp;
        sbq.push_back(sb);
        @(posedge clk);
        #1;
        sb = sbq.pop_front();
        cmp(sb.nm, act(), sb.exp);
      end
    end

    // Async reset mid-LOCKED: outputs drop before any clock edge.
    rst = 1'b1;
    #1 cmp("async_rst", act(), xi);
    @(posedge clk);
    #1 cmp("rst_held", act(), xi);
    rst = 1'b0;
    @(posedge clk);
    #1 cmp("rst_recover", act(), xd);
    bus.acq_req = 4'b0001;
    @(posedge clk);
    #1 cmp("post_rst_set", act(), xs);
    bus.acq_req = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1 cmp("post_rst_grant", act(), o(4'b0001, 1, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
